// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if -- handshake bundle between the datapath and the pipeline
// controller.
//
//   Datapath -> controller (status):
//     ihit        instruction fetch complete this cycle
//     dreq/dhit   memory stage holds a load/store / data access complete
//     id_valid    latch 0 (IF/ID) holds a real instruction
//     id_rs/id_rt source registers of the decoding instruction
//     id_use_rs/id_use_rt  decoding instruction reads rs / rt
//     id_rd/id_wr/id_ld    destination, writes-register, is-a-load
//     br_taken    branch stage redirects the PC
//     halt_req    halt instruction sits in the memory stage
//   Controller -> datapath (control):
//     pc_en       PC update enable
//     en          per-latch load enable (bit k = latch k)
//     flush       per-latch bubble insert, effective on the clock edge
//     halted      pipeline drained and frozen
//     stall_cnt   saturating count of stall cycles
//
// Modports: master = datapath side, slave = controller side.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int NSTAGES = 5,
  parameter int REGW    = 5,
  parameter int CNTW    = 16
);
  logic               ihit;
  logic               dreq;
  logic               dhit;
  logic               id_valid;
  logic [REGW-1:0]    id_rs;
  logic [REGW-1:0]    id_rt;
  logic               id_use_rs;
  logic               id_use_rt;
  logic [REGW-1:0]    id_rd;
  logic               id_wr;
  logic               id_ld;
  logic               br_taken;
  logic               halt_req;

  logic               pc_en;
  logic [NSTAGES-2:0] en;
  logic [NSTAGES-2:0] flush;
  logic               halted;
  logic [CNTW-1:0]    stall_cnt;

  modport master (
    output ihit, dreq, dhit, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_rd, id_wr, id_ld, br_taken, halt_req,
    input  pc_en, en, flush, halted, stall_cnt
  );

  modport slave (
    input  ihit, dreq, dhit, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_rd, id_wr, id_ld, br_taken, halt_req,
    output pc_en, en, flush, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- hazard / stall / flush controller for an in-order pipeline
// of NSTAGES stages with NSTAGES-1 inter-stage latches (0 = IF/ID).
//
//   CLK  sole clock, rising edge
//   RST  synchronous, active-high reset
//   bus  pipe_ctrl_if.slave: datapath status in, pc_en/en/flush out
//        (combinational), halted/stall_cnt out (registered)
//
// A small scoreboard shadows latches 1..NSTAGES-2 so that a load still
// short of LD_STAGE can stall a dependent instruction in decode. Priority
// in RUN: memory stall > branch redirect > load-use > fetch miss.
// A halt drains the pipe for NSTAGES-1 advancing cycles, then freezes
// until reset.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int NSTAGES  = 5,
  parameter int LD_STAGE = 3,
  parameter int BR_STAGE = 2,
  parameter int REGW     = 5,
  parameter int CNTW     = 16
) (
  input  logic        CLK,
  input  logic        RST,
  pipe_ctrl_if.slave  bus
);

  localparam int NL  = NSTAGES - 1;           // number of latches
  localparam int NSB = NSTAGES - 2;           // scoreboard entries 1..NSB
  localparam int DCW = $clog2(NSTAGES - 1);   // holds NSTAGES-2

  localparam logic [NL-1:0] BR_MASK  = NL'((1 << BR_STAGE) - 1);
  localparam logic [NL-1:0] IF_FLUSH = NL'(1);
  localparam logic [NL-1:0] LU_FLUSH = NL'(2);
  localparam logic [NL-1:0] LU_EN    = ~NL'(1);

  typedef enum logic [1:0] {RUN, MISS, DRAIN, HALT} state_t;

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rd;
    logic            wr;
    logic            ld;
  } sb_t;

  state_t          state;
  logic [DCW-1:0]  drain_cnt;
  logic            halted_q;
  logic [CNTW-1:0] stall_q;
  sb_t             sb [1:NSB];

  logic            mem_stall;
  logic            ld_hazard;
  logic            run_ctl;     // RUN priority rules apply this cycle
  logic            pc_en_c;
  logic [NL-1:0]   en_c;
  logic [NL-1:0]   flush_c;
  logic            unused_sb;

  assign mem_stall = bus.dreq & ~bus.dhit;

  // A load in latch k (1 <= k <= LD_STAGE-1) has not yet returned its data
  // early enough for the instruction in decode; r0 never carries a hazard.
  always_comb begin
    ld_hazard = 1'b0;
    for (int k = 1; k < LD_STAGE; k++) begin
      if (sb[k].valid && sb[k].ld && (sb[k].rd != '0) &&
          ((bus.id_use_rs && (bus.id_rs == sb[k].rd)) ||
           (bus.id_use_rt && (bus.id_rt == sb[k].rd))))
        ld_hazard = 1'b1;
    end
    ld_hazard = ld_hazard & bus.id_valid;
  end

  // The wr flag is kept alongside each entry for the datapath's view of the
  // pipe; no stall rule consumes it.
  always_comb begin
    unused_sb = 1'b0;
    for (int k = 1; k <= NSB; k++) unused_sb = unused_sb ^ sb[k].wr;
  end

  // Control outputs are purely combinational so a stall takes effect on the
  // very edge that would otherwise have advanced the pipe.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // through this block can leave a value held and infer a latch.
    pc_en_c = 1'b0;
    en_c    = '0;
    flush_c = '0;
    run_ctl = 1'b0;
    if (RST) begin
      flush_c = '1;
    end else begin
      unique case (state)
        RUN:   run_ctl = ~mem_stall;
        MISS:  run_ctl = bus.dhit;
        DRAIN: if (!mem_stall) begin
                 en_c    = '1;
                 flush_c = IF_FLUSH;
               end
        HALT:  ;
        default: ;
      endcase
    end

    if (run_ctl) begin
      if (bus.br_taken) begin
        // Wrong-path instructions younger than the branch become bubbles;
        // flush wins over en on the flushed latches.
        pc_en_c = 1'b1;
        en_c    = '1;
        flush_c = BR_MASK;
      end else if (ld_hazard) begin
        en_c    = LU_EN;
        flush_c = LU_FLUSH;
      end else if (!bus.ihit) begin
        en_c    = '1;
        flush_c = IF_FLUSH;
      end else begin
        pc_en_c = 1'b1;
        en_c    = '1;
      end
    end
  end

  assign bus.pc_en     = pc_en_c;
  assign bus.en        = en_c;
  assign bus.flush     = flush_c;
  assign bus.halted    = halted_q;
  assign bus.stall_cnt = stall_q;

  // FSM, drain counter, halted flag and stall counter.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted_q  <= 1'b0;
      stall_q   <= '0;
    end else begin
      if ((state != HALT) && !pc_en_c && (stall_q != '1))
        stall_q <= stall_q + CNTW'(1);

      unique case (state)
        RUN, MISS: begin
          if (!run_ctl) begin
            state <= MISS;
          end else if (bus.halt_req) begin
            state     <= DRAIN;
            drain_cnt <= DCW'(NSTAGES - 2);
          end else begin
            state <= RUN;
          end
        end
        DRAIN: begin
          if (!mem_stall) begin
            if (drain_cnt == '0) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

  // Scoreboard shadowing latches 1..NSB; flush overrides en.
  always_ff @(posedge CLK) begin
    // NOTE: only the valid bits are reset; rd/wr/ld are don't-care while
    // an entry is invalid, so the payload needs no reset.
    if (RST) begin
      for (int k = 1; k <= NSB; k++) sb[k].valid <= 1'b0;
    end else begin
      if (flush_c[1])
        sb[1] <= '0;
      else if (en_c[1])
        sb[1] <= '{valid: bus.id_valid, rd: bus.id_rd, wr: bus.id_wr,
                   ld: bus.id_ld};
      for (int k = 2; k <= NSB; k++) begin
        if (flush_c[k])
          sb[k] <= '0;
        else if (en_c[k])
          sb[k] <= sb[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (NSTAGES=5, LD_STAGE=3,
// BR_STAGE=2). A second instance with a 4-bit stall counter shares the same
// stimulus. A behavioural model (mode, list of in-flight instructions, plain
// stall tally) predicts every output each cycle; directed scenarios add
// explicit expectations on top.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int NS  = 5;
  localparam int LD  = 3;
  localparam int BR  = 2;
  localparam int RW  = 5;
  localparam int CW  = 16;
  localparam int CWN = 4;
  localparam int NL  = NS - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.NSTAGES(NS), .REGW(RW), .CNTW(CW))  bus ();
  pipe_ctrl_if #(.NSTAGES(NS), .REGW(RW), .CNTW(CWN)) bus_n ();

  pipe_ctrl #(.NSTAGES(NS), .LD_STAGE(LD), .BR_STAGE(BR), .REGW(RW), .CNTW(CW))
    dut (.CLK(clk), .RST(rst), .bus(bus));

  pipe_ctrl #(.NSTAGES(NS), .LD_STAGE(LD), .BR_STAGE(BR), .REGW(RW), .CNTW(CWN))
    dut_n (.CLK(clk), .RST(rst), .bus(bus_n));

  always_comb begin
    bus_n.ihit      = bus.ihit;
    bus_n.dreq      = bus.dreq;
    bus_n.dhit      = bus.dhit;
    bus_n.id_valid  = bus.id_valid;
    bus_n.id_rs     = bus.id_rs;
    bus_n.id_rt     = bus.id_rt;
    bus_n.id_use_rs = bus.id_use_rs;
    bus_n.id_use_rt = bus.id_use_rt;
    bus_n.id_rd     = bus.id_rd;
    bus_n.id_wr     = bus.id_wr;
    bus_n.id_ld     = bus.id_ld;
    bus_n.br_taken  = bus.br_taken;
    bus_n.halt_req  = bus.halt_req;
  end

  // ---------------- reference model ----------------
  typedef enum {M_RUN, M_MISS, M_DRAIN, M_HALT} mode_t;
  typedef struct {bit v; int rd; bit ld;} slot_t;

  mode_t mode;
  slot_t pipe [1:NL-1];   // instruction held in latch k
  int    drain_left;
  int    stalls;

  int n_checks = 0;
  int n_fail   = 0;

  bit          o_pc;
  bit [NL-1:0] o_en, o_fl;
  bit          e_pc;
  bit [NL-1:0] e_en, e_fl;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit m_hazard();
    bit h = 0;
    for (int k = 1; k <= LD - 1; k++)
      if (pipe[k].v && pipe[k].ld && pipe[k].rd != 0 &&
          ((bus.id_use_rs && int'(bus.id_rs) == pipe[k].rd) ||
           (bus.id_use_rt && int'(bus.id_rt) == pipe[k].rd)))
        h = 1;
    return h && bus.id_valid;
  endfunction

  function automatic bit m_live();
    bit mem_wait = bus.dreq && !bus.dhit;
    if (mode == M_RUN)  return !mem_wait;
    if (mode == M_MISS) return bus.dhit;
    return 0;
  endfunction

  function automatic void predict(output bit pc, output bit [NL-1:0] en,
                                  output bit [NL-1:0] fl);
    pc = 0; en = '0; fl = '0;
    if (rst) begin fl = '1; return; end
    if (mode == M_HALT) return;
    if (mode == M_DRAIN) begin
      if (!(bus.dreq && !bus.dhit)) begin en = '1; fl[0] = 1; end
      return;
    end
    if (!m_live()) return;
    if (bus.br_taken) begin
      pc = 1; en = '1;
      for (int k = 0; k < BR; k++) fl[k] = 1;
    end else if (m_hazard()) begin
      en = '1; en[0] = 0; fl[1] = 1;
    end else if (!bus.ihit) begin
      en = '1; fl[0] = 1;
    end else begin
      pc = 1; en = '1;
    end
  endfunction

  task automatic model_clock(input bit pc, input bit [NL-1:0] en,
                             input bit [NL-1:0] fl);
    bit live = m_live();
    if (rst) begin
      mode = M_RUN; drain_left = 0; stalls = 0;
      for (int k = 1; k <= NL - 1; k++) pipe[k].v = 0;
      return;
    end
    if (mode != M_HALT && !pc) stalls++;
    // oldest first so each latch reads its predecessor's pre-edge content
    for (int k = NL - 1; k >= 1; k--) begin
      if (fl[k]) pipe[k] = '{0, 0, 0};
      else if (en[k])
        pipe[k] = (k == 1) ? '{bus.id_valid, int'(bus.id_rd), bus.id_ld}
                           : pipe[k-1];
    end
    case (mode)
      M_RUN, M_MISS:
        if (!live) mode = M_MISS;
        else if (bus.halt_req) begin mode = M_DRAIN; drain_left = NS - 2; end
        else mode = M_RUN;
      M_DRAIN:
        if (!(bus.dreq && !bus.dhit)) begin
          if (drain_left == 0) mode = M_HALT;
          else drain_left--;
        end
      default: ;
    endcase
  endtask

  // One clock: compare everything at the falling edge, advance the model
  // on the rising edge, return 1 time unit later for the next stimulus.
  task automatic cycle();
    @(negedge clk);
    predict(e_pc, e_en, e_fl);
    o_pc = bus.pc_en; o_en = bus.en; o_fl = bus.flush;
    check("pc_en", 32'(o_pc), 32'(e_pc));
    check("en", 32'(o_en), 32'(e_en));
    check("flush", 32'(o_fl), 32'(e_fl));
    check("halted", 32'(bus.halted), 32'(mode == M_HALT));
    check("stall_cnt", 32'(bus.stall_cnt), sat(stalls, CW));
    check("stall_cnt_w4", 32'(bus_n.stall_cnt), sat(stalls, CWN));
    @(posedge clk);
    model_clock(e_pc, e_en, e_fl);
    #1;
  endtask

  task automatic idle();
    bus.ihit = 1; bus.dreq = 0; bus.dhit = 0;
    bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_rd = '0; bus.id_wr = 0; bus.id_ld = 0;
    bus.br_taken = 0; bus.halt_req = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  task automatic load_r4();
    bus.id_valid = 1; bus.id_rd = 5'd4; bus.id_wr = 1; bus.id_ld = 1;
    cycle();
    bus.id_ld = 0; bus.id_rd = 5'd5;
  endtask

  initial begin
    idle();
    rst = 1;
    mode = M_RUN; drain_left = 0; stalls = 0;
    for (int k = 1; k <= NL - 1; k++) pipe[k] = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;

    // Outputs while reset is held
    cycle();
    check("rst_pc_en", 32'(o_pc), 0);
    check("rst_en", 32'(o_en), 0);
    check("rst_flush", 32'(o_fl), 32'hf);
    rst = 0;

    // Load-use: one stall cycle, then full advance once the consumer moves on
    load_r4();
    bus.id_rs = 5'd4; bus.id_use_rs = 1;
    cycle();
    check("lu_pc_en", 32'(o_pc), 0);
    check("lu_en", 32'(o_en), 32'b1110);
    check("lu_flush", 32'(o_fl), 32'b0010);
    check("lu_cnt", 32'(bus.stall_cnt), 1);
    bus.id_use_rs = 0;
    cycle();
    check("lu_after_en", 32'(o_en), 32'hf);
    check("lu_after_pc", 32'(o_pc), 1);

    // Data miss for 3 cycles, then hit
    do_reset();
    bus.dreq = 1; bus.dhit = 0;
    repeat (3) begin
      cycle();
      check("miss_en", 32'(o_en), 0);
      check("miss_pc", 32'(o_pc), 0);
    end
    check("miss_cnt", 32'(bus.stall_cnt), 3);
    bus.dhit = 1;
    cycle();
    check("miss_hit_en", 32'(o_en), 32'hf);
    check("miss_hit_pc", 32'(o_pc), 1);
    bus.dreq = 0; bus.dhit = 0;
    cycle();
    check("miss_back_run", 32'(o_en), 32'hf);

    // Branch together with a load-use hazard: branch wins, no stall
    do_reset();
    load_r4();
    bus.id_rs = 5'd4; bus.id_use_rs = 1; bus.br_taken = 1;
    cycle();
    check("br_pc_en", 32'(o_pc), 1);
    check("br_flush", 32'(o_fl), 32'b0011);
    check("br_cnt", 32'(bus.stall_cnt), 0);
    idle();

    // Halt drain: 4 drain cycles, then frozen
    do_reset();
    bus.halt_req = 1;
    cycle();
    check("halt_req_pc", 32'(o_pc), 1);
    check("halt_not_yet", 32'(bus.halted), 0);
    bus.halt_req = 0;
    for (int i = 0; i < 4; i++) begin
      check("drain_halted", 32'(bus.halted), 0);
      cycle();
      check("drain_pc", 32'(o_pc), 0);
      check("drain_flush", 32'(o_fl), 32'b0001);
      check("drain_en", 32'(o_en), 32'hf);
    end
    check("halted_set", 32'(bus.halted), 1);
    cycle();
    check("halt_en", 32'(o_en), 0);
    bus.ihit = 0;
    cycle();
    check("halt_ihit_en", 32'(o_en), 0);
    check("halt_ihit_flush", 32'(o_fl), 0);
    check("halt_ihit_pc", 32'(o_pc), 0);
    check("halt_hold", 32'(bus.halted), 1);
    check("halt_cnt", 32'(bus.stall_cnt), 4);
    bus.ihit = 1;

    // Reset in the middle of a drain wipes the scoreboard
    do_reset();
    load_r4();
    bus.id_valid = 0; bus.halt_req = 1;
    cycle();
    bus.halt_req = 0;
    rst = 1;
    cycle();
    rst = 0;
    check("rst_drain_halted", 32'(bus.halted), 0);
    check("rst_drain_cnt", 32'(bus.stall_cnt), 0);
    bus.id_valid = 1; bus.id_rs = 5'd4; bus.id_use_rs = 1;
    cycle();
    check("rst_drain_nostall", 32'(o_pc), 1);
    idle();

    // Narrow counter saturates at 15
    do_reset();
    bus.ihit = 0;
    repeat (20) cycle();
    check("sat_w4", 32'(bus_n.stall_cnt), 15);
    check("sat_w16", 32'(bus.stall_cnt), 20);
    cycle();
    check("sat_w4_hold", 32'(bus_n.stall_cnt), 15);
    idle();

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 59) == 0);
      bus.ihit       = ($urandom_range(0, 4) != 0);
      bus.dreq       = ($urandom_range(0, 3) == 0);
      bus.dhit       = $urandom_range(0, 1) == 1;
      bus.id_valid   = ($urandom_range(0, 3) != 0);
      bus.id_rs      = 5'($urandom_range(0, 3));
      bus.id_rt      = 5'($urandom_range(0, 3));
      bus.id_rd      = 5'($urandom_range(0, 3));
      bus.id_use_rs  = $urandom_range(0, 1) == 1;
      bus.id_use_rt  = $urandom_range(0, 1) == 1;
      bus.id_wr      = $urandom_range(0, 1) == 1;
      bus.id_ld      = ($urandom_range(0, 2) == 0);
      bus.br_taken   = ($urandom_range(0, 7) == 0);
      bus.halt_req   = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NSTAGES, 5, pipeline depth; NSTAGES-1 inter-stage latches numbered 0 (IF/ID) to NSTAGES-2; legal range 3..8.
- LD_STAGE, 3, stage returning load data; legal range 2..NSTAGES-1.
- BR_STAGE, 2, stage resolving branches and jumps; legal range 1..NSTAGES-2.
- REGW, 5, register-index width.
- CNTW, 16, stall-counter width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK, in, 1, sole clock; all state updates on rising edge.
- RST, in, 1, reset; synchronous and active-high.
- ihit, in, 1, instruction fetch complete this cycle.
- dreq, in, 1, memory stage holds a load or store.
- dhit, in, 1, data access complete this cycle.
- id_valid, in, 1, latch 0 holds a real instruction.
- id_rs, in, REGW, source register 1 of the decoding instruction.
- id_rt, in, REGW, source register 2 of the decoding instruction.
- id_use_rs, in, 1, the decoding instruction reads rs.
- id_use_rt, in, 1, the decoding instruction reads rt.
- id_rd, in, REGW, destination of the decoding instruction.
- id_wr, in, 1, the decoding instruction writes a register.
- id_ld, in, 1, the decoding instruction is a load.
- br_taken, in, 1, stage BR_STAGE redirects the PC.
- halt_req, in, 1, a halt instruction is in the memory stage.
- pc_en, out, 1, PC update enable.
- en, out, NSTAGES-1, per-latch load enable.
- flush, out, NSTAGES-1, per-latch bubble insert; takes effect on the edge.
- halted, out, 1, pipeline drained and frozen.
- stall_cnt, out, CNTW, saturating count of stall cycles.

Function
REQ-003 FSM states: RUN, MISS, DRAIN, HALT.
REQ-004 The scoreboard shall hold {valid, rd, wr, ld} for latches 1..NSTAGES-2.
REQ-005 Scoreboard entry k shall shift from entry k-1 when en[k]=1; entry 1 shall load from the id_* inputs.
REQ-006 A scoreboard entry shall be cleared when flush[k]=1; flush shall override en.
REQ-007 A load-use hazard shall be raised when id_valid=1 and the id_rs (gated by id_use_rs) or id_rt (gated by id_use_rt) value equals rd of a valid ld entry k, where 1<=k<=LD_STAGE-1 and rd!=0.
REQ-008 RUN, priority 1: dreq=1 and dhit=0 shall force pc_en=0 and en=0 combinationally; the FSM shall go to MISS.
REQ-009 RUN, priority 2: br_taken=1 shall force pc_en=1 and flush[k]=1 for every latch k<BR_STAGE; older latches shall advance; any load-use hazard shall be ignored that cycle.
REQ-010 RUN, priority 3: a load-use hazard shall force pc_en=0, en[0]=0 and flush[1]=1; latches 2 and above shall advance.
REQ-011 RUN, priority 4: ihit=0 shall force pc_en=0 and flush[0]=1; latches 1 and above shall advance.
REQ-012 RUN, otherwise: pc_en=1, en=all ones, flush=0.
REQ-013 MISS: pc_en=0 and en=0 while dhit=0; the first cycle with dhit=1 shall behave as RUN, and the FSM shall return to RUN.
REQ-014 halt_req=1 in RUN with no memory stall shall enter DRAIN and load the drain counter with NSTAGES-2.
REQ-015 DRAIN: pc_en=0, flush[0]=1 and the other latches shall advance; a memory stall shall freeze everything including the counter.
REQ-016 DRAIN: the counter shall decrement on each advancing cycle; the FSM shall enter HALT after the cycle in which the counter is 0.
REQ-017 HALT: halted=1, pc_en=0, en=0, flush=0; HALT shall be left only by reset.
REQ-018 halt_req=1 coinciding with br_taken=1 shall apply the branch flush that cycle and still enter DRAIN.
REQ-019 stall_cnt shall increment on every cycle in RUN, MISS or DRAIN with pc_en=0.
REQ-020 stall_cnt shall saturate at 2^CNTW-1 and shall never wrap.
REQ-021 The en, flush and pc_en outputs shall be combinational from the current state and inputs, with no added latency.
REQ-022 The FSM, the scoreboard and stall_cnt shall be registered.

Reset
REQ-023 RST=1 at a clock edge shall set state RUN, clear every scoreboard valid bit, set stall_cnt=0, halted=0 and drain counter=0, overriding all other inputs.
REQ-024 While RST=1, outputs shall be pc_en=0, en=0 and flush=all ones.
REQ-025 A reset asserted in MISS, DRAIN or HALT shall return the block to the REQ-023 state at the next edge.

Verification (NSTAGES=5, LD_STAGE=3, BR_STAGE=2)
REQ-026 Load r4 in latch 1, next id_rs=4 with id_use_rs=1 -> one cycle of pc_en=0, en=4'b1110, flush=4'b0010, stall_cnt=1; then full advance.
REQ-027 dreq=1, dhit=0 for 3 cycles, then dhit=1 -> en=0 for 3 cycles, state MISS, stall_cnt=3; 4th cycle en=4'b1111, state RUN.
REQ-028 br_taken=1 together with a load-use hazard -> pc_en=1, flush=4'b0011, no stall, stall_cnt unchanged.
REQ-029 halt_req=1 with no stalls -> DRAIN for 4 cycles (counter 3 to 0), then halted=1 and en=0; a later ihit=0 pulse changes nothing.
REQ-030 CNTW=4 with 20 stall cycles -> stall_cnt=15 and holds.
REQ-031 RST=1 mid-DRAIN -> next cycle state RUN, halted=0, stall_cnt=0, scoreboard empty; id_rs matching a prior load rd raises no stall.
